// File: rtl/count_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_sweep_pkg
//  Description : Shared state encoding and default widths for the step-counter
//                sweep sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package count_sweep_pkg;

  localparam int C_COUNT_W = 8;
  localparam int C_STEP_W  = 4;
  localparam int C_PASS_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_INIT_CHK = 3'd2,
    ST_UP_ISSUE = 3'd3,
    ST_UP_CHK   = 3'd4,
    ST_DN_ISSUE = 3'd5,
    ST_DN_CHK   = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  // A sweep is in progress in every state except the two resting states.
  function automatic logic is_busy(input state_t s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_checker
//  Description : Tracks the count value the counter should return, compares
//                it with the fed-back count and evaluates the sweep limits.
//  Revision    : 1.0  initial release
// ============================================================================
module sweep_checker
  import count_sweep_pkg::*;
#(
  parameter int P_COUNT_W = C_COUNT_W,
  parameter int P_STEP_W  = C_STEP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_add,
  input  logic                 i_sub,
  input  logic [P_STEP_W-1:0]  i_step,
  input  logic [P_COUNT_W-1:0] i_lower,
  input  logic [P_COUNT_W-1:0] i_upper,
  input  logic [P_COUNT_W-1:0] i_count,
  output logic                 o_mismatch,
  output logic                 o_up_limit,
  output logic                 o_dn_limit
);

  localparam int C_WIDE_W = P_COUNT_W + 1;

  logic [P_COUNT_W-1:0] expected_q;
  logic [P_COUNT_W-1:0] expected_d;
  logic [P_COUNT_W-1:0] step_ext;
  logic [C_WIDE_W-1:0]  count_plus_step;
  logic [C_WIDE_W-1:0]  lower_plus_step;

  assign step_ext = P_COUNT_W'(i_step);

  // Expected value follows the counter contract: cleared with the counter,
  // moved by N (modulo width) whenever a step pulse is issued.
  always_comb begin
    expected_d = expected_q;
    if (i_clear) begin
      expected_d = '0;
    end else if (i_add) begin
      expected_d = expected_q + step_ext;
    end else if (i_sub) begin
      expected_d = expected_q - step_ext;
    end
  end

  // Expected-value register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected_q <= '0;
    end else begin
      expected_q <= expected_d;
    end
  end

  // Limit tests are widened by one bit so a step past the top never wraps.
  always_comb begin
    count_plus_step = C_WIDE_W'(i_count) + C_WIDE_W'(i_step);
    lower_plus_step = C_WIDE_W'(i_lower) + C_WIDE_W'(i_step);
    o_mismatch      = (i_count != expected_q);
    o_up_limit      = (count_plus_step > C_WIDE_W'(i_upper));
    o_dn_limit      = (C_WIDE_W'(i_count) < lower_plus_step);
  end

endmodule
`default_nettype wire

// File: rtl/count_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : count_sweep_ctrl
//  Description : Command sequencer for the step counter. Runs a programmable
//                number of up/down sweeps between two limits, checks every
//                returned count and tallies midpoint indications.
//  Revision    : 1.0  initial release
// ============================================================================
module count_sweep_ctrl
  import count_sweep_pkg::*;
#(
  parameter int P_COUNT_W = C_COUNT_W,
  parameter int P_STEP_W  = C_STEP_W,
  parameter int P_PASS_W  = C_PASS_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [P_STEP_W-1:0]  i_step,
  input  logic [P_COUNT_W-1:0] i_lower_limit,
  input  logic [P_COUNT_W-1:0] i_upper_limit,
  input  logic [P_PASS_W-1:0]  i_passes,
  input  logic [P_COUNT_W-1:0] i_count,
  input  logic                 i_at_midpoint,
  output logic                 o_initialize_count,
  output logic                 o_count_up,
  output logic                 o_enable_count,
  output logic [P_STEP_W-1:0]  o_n,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [P_PASS_W-1:0]  o_pass_count,
  output logic [P_COUNT_W-1:0] o_midpoint_hits
);

  localparam logic [P_PASS_W-1:0] C_PASS_ONE = P_PASS_W'(1);

  state_t               state_q,  state_d;
  logic [P_STEP_W-1:0]  step_q,   step_d;
  logic [P_COUNT_W-1:0] lower_q,  lower_d;
  logic [P_COUNT_W-1:0] upper_q,  upper_d;
  logic [P_PASS_W-1:0]  passes_q, passes_d;
  logic [P_PASS_W-1:0]  pass_q,   pass_d;
  logic [P_COUNT_W-1:0] hits_q,   hits_d;
  logic                 error_q,  error_d;
  logic                 init_q,   init_d;
  logic                 en_q,     en_d;
  logic                 up_q,     up_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;

  logic chk_clear;
  logic chk_add;
  logic chk_sub;
  logic chk_mismatch;
  logic chk_up_limit;
  logic chk_dn_limit;
  logic in_check;

  sweep_checker #(
    .P_COUNT_W (P_COUNT_W),
    .P_STEP_W  (P_STEP_W)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (chk_clear),
    .i_add      (chk_add),
    .i_sub      (chk_sub),
    .i_step     (step_q),
    .i_lower    (lower_q),
    .i_upper    (upper_q),
    .i_count    (i_count),
    .o_mismatch (chk_mismatch),
    .o_up_limit (chk_up_limit),
    .o_dn_limit (chk_dn_limit)
  );

  assign in_check = (state_q == ST_INIT_CHK) || (state_q == ST_UP_CHK) ||
                    (state_q == ST_DN_CHK);

  // Next-state, captured sweep parameters, status and checker commands.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    lower_d   = lower_q;
    upper_d   = upper_q;
    passes_d  = passes_q;
    pass_d    = pass_q;
    hits_d    = hits_q;
    error_d   = error_q;
    chk_clear = 1'b0;
    chk_add   = 1'b0;
    chk_sub   = 1'b0;

    if (i_stop) begin
      // Abort freezes all status; in IDLE this also masks a coincident start.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            if ((i_step == '0) || (i_upper_limit <= i_lower_limit)) begin
              state_d = ST_DONE;
              error_d = 1'b1;
            end else begin
              step_d    = i_step;
              lower_d   = i_lower_limit;
              upper_d   = i_upper_limit;
              passes_d  = (i_passes == '0) ? C_PASS_ONE : i_passes;
              pass_d    = '0;
              hits_d    = '0;
              error_d   = 1'b0;
              chk_clear = 1'b1;
              state_d   = ST_INIT;
            end
          end
        end
        ST_INIT: begin
          state_d = ST_INIT_CHK;
        end
        ST_INIT_CHK: begin
          if (i_count != '0) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            chk_clear = 1'b1;
            state_d   = ST_UP_ISSUE;
          end
        end
        ST_UP_ISSUE: begin
          chk_add = 1'b1;
          state_d = ST_UP_CHK;
        end
        ST_UP_CHK: begin
          if (chk_mismatch) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else if (chk_up_limit) begin
            state_d = ST_DN_ISSUE;
          end else begin
            state_d = ST_UP_ISSUE;
          end
        end
        ST_DN_ISSUE: begin
          chk_sub = 1'b1;
          state_d = ST_DN_CHK;
        end
        ST_DN_CHK: begin
          if (chk_mismatch) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else if (chk_dn_limit) begin
            pass_d  = pass_q + C_PASS_ONE;
            state_d = ((pass_q + C_PASS_ONE) == passes_q) ? ST_DONE : ST_UP_ISSUE;
          end else begin
            state_d = ST_DN_ISSUE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (in_check && i_at_midpoint && (hits_q != '1)) begin
        hits_d = hits_q + P_COUNT_W'(1);
      end
    end
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    init_d = (state_d == ST_INIT);
    en_d   = (state_d == ST_UP_ISSUE) || (state_d == ST_DN_ISSUE);
    up_d   = (state_d == ST_UP_ISSUE) || (state_d == ST_UP_CHK);
    busy_d = is_busy(state_d);
    done_d = (state_d == ST_DONE);
  end

  // State, parameter, status and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      lower_q  <= '0;
      upper_q  <= '0;
      passes_q <= '0;
      pass_q   <= '0;
      hits_q   <= '0;
      error_q  <= 1'b0;
      init_q   <= 1'b0;
      en_q     <= 1'b0;
      up_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      lower_q  <= lower_d;
      upper_q  <= upper_d;
      passes_q <= passes_d;
      pass_q   <= pass_d;
      hits_q   <= hits_d;
      error_q  <= error_d;
      init_q   <= init_d;
      en_q     <= en_d;
      up_q     <= up_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_initialize_count = init_q;
  assign o_count_up         = up_q;
  assign o_enable_count     = en_q;
  assign o_n                = step_q;
  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_error            = error_q;
  assign o_pass_count       = pass_q;
  assign o_midpoint_hits    = hits_q;

endmodule
`default_nettype wire

// File: tb/tb_count_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_sweep_ctrl
//  Description : Self-checking bench for count_sweep_ctrl with a model step
//                counter and a sweep-sequence reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_count_sweep_ctrl;

  localparam int CW = 8;
  localparam int SW = 4;
  localparam int PW = 4;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          start  = 1'b0;
  logic          stop   = 1'b0;
  logic          at_mid = 1'b0;
  logic [SW-1:0] step   = '0;
  logic [CW-1:0] lower  = '0;
  logic [CW-1:0] upper  = '0;
  logic [PW-1:0] passes = '0;
  logic [CW-1:0] cnt;

  logic          init_o, up_o, en_o, busy_o, done_o, err_o;
  logic [SW-1:0] n_o;
  logic [PW-1:0] pass_o;
  logic [CW-1:0] hits_o;

  int n_tests = 0;
  int n_fail  = 0;

  int  obs_val[$];
  bit  obs_dir[$];
  int  pulses   = 0;
  int  consec   = 0;
  bit  prev_en  = 1'b0;
  bit  inject   = 1'b0;
  bit  injected = 1'b0;
  logic [CW-1:0] mc_next;

  count_sweep_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .i_start            (start),
    .i_stop             (stop),
    .i_step             (step),
    .i_lower_limit      (lower),
    .i_upper_limit      (upper),
    .i_passes           (passes),
    .i_count            (cnt),
    .i_at_midpoint      (at_mid),
    .o_initialize_count (init_o),
    .o_count_up         (up_o),
    .o_enable_count     (en_o),
    .o_n                (n_o),
    .o_busy             (busy_o),
    .o_done             (done_o),
    .o_error            (err_o),
    .o_pass_count       (pass_o),
    .o_midpoint_hits    (hits_o)
  );

  always #5 clk = ~clk;

  // Model step counter; optionally corrupts the first upward result of 6.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (init_o) begin
      cnt <= '0;
    end else if (en_o) begin
      mc_next = up_o ? (cnt + CW'(n_o)) : (cnt - CW'(n_o));
      if (inject && !injected && up_o && (mc_next == CW'(6))) begin
        mc_next  = CW'(7);
        injected = 1'b1;
      end
      cnt <= mc_next;
      obs_val.push_back(int'(mc_next));
      obs_dir.push_back(up_o);
      pulses++;
    end
  end

  // Watch for back-to-back step pulses.
  always @(negedge clk) begin
    if (en_o && prev_en) consec++;
    prev_en <= en_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue_start(input int lo, input int hi, input int st, input int ps, input bit mid);
    @(negedge clk);
    lower  = CW'(lo);
    upper  = CW'(hi);
    step   = SW'(st);
    passes = PW'(ps);
    at_mid = mid;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Full sweep checked against a sequence built from the sweep rules.
  task automatic run_sweep(input int lo, input int hi, input int st, input int ps, input bit mid);
    int exp_val[$];
    bit exp_dir[$];
    int c_val, p_done, eff, base, c, nchk;
    eff    = (ps == 0) ? 1 : ps;
    c_val  = 0;
    p_done = 0;
    while (p_done < eff) begin
      do begin
        c_val += st;
        exp_val.push_back(c_val);
        exp_dir.push_back(1'b1);
      end while (c_val + st <= hi);
      do begin
        c_val -= st;
        exp_val.push_back(c_val);
        exp_dir.push_back(1'b0);
      end while (c_val >= lo + st);
      p_done++;
    end
    nchk = 1 + exp_val.size();
    base = obs_val.size();
    issue_start(lo, hi, st, ps, mid);
    check("init_pulse", init_o, 1);
    check("busy_rise", busy_o, 1);
    check("n_reg", n_o, st);
    check("pass_clear", pass_o, 0);
    c = 1;
    while (!done_o && c < 6000) begin
      @(negedge clk);
      c++;
    end
    check("done_cycle", c, 3 + 2 * exp_val.size());
    check("busy_fall", busy_o, 0);
    check("err_clean", err_o, 0);
    check("pass_count", pass_o, eff);
    check("mid_hits", hits_o, mid ? ((nchk > 255) ? 255 : nchk) : 0);
    check("seq_len", obs_val.size() - base, exp_val.size());
    for (int i = 0; i < exp_val.size(); i++) begin
      if (base + i < obs_val.size()) begin
        check("seq_val", obs_val[base+i], exp_val[i]);
        check("seq_dir", obs_dir[base+i], exp_dir[i]);
      end
    end
  endtask

  task automatic run_bad(input int lo, input int hi, input int st);
    int p0;
    p0 = pulses;
    issue_start(lo, hi, st, 1, 1'b0);
    check("bad_done", done_o, 1);
    check("bad_err", err_o, 1);
    check("bad_busy", busy_o, 0);
    check("bad_init", init_o, 0);
    repeat (3) @(negedge clk);
    check("bad_no_en", pulses - p0, 0);
    check("bad_done_hold", done_o, 1);
  endtask

  initial begin
    int c, p0;

    repeat (2) @(negedge clk);
    check("rst_state", {init_o, up_o, en_o, n_o, busy_o, done_o, err_o, pass_o, hits_o}, 0);
    rst = 1'b0;

    // Directed reference sweep.
    run_sweep(0, 12, 3, 1, 1'b0);

    // Rejected starts, then a good start clears the sticky error.
    run_bad(0, 12, 0);
    run_bad(5, 5, 3);
    run_sweep(2, 9, 2, 2, 1'b1);

    // Corrupted count return.
    inject = 1'b1;
    p0 = pulses;
    issue_start(0, 20, 3, 1, 1'b0);
    c = 1;
    while (!done_o && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("inj_done_cycle", c, 7);
    check("inj_err", err_o, 1);
    check("inj_pulses", pulses - p0, 2);
    repeat (3) @(negedge clk);
    check("inj_no_more_en", pulses - p0, 2);
    inject = 1'b0;

    // Abort during an upward check of the second pass.
    issue_start(0, 30, 2, 2, 1'b0);
    c = 0;
    while (!(pass_o == 1 && up_o && !en_o && busy_o) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("stop_reach", c < 2000, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", busy_o, 0);
    check("stop_done", done_o, 0);
    check("stop_pass", pass_o, 1);
    check("stop_pulses", {init_o, en_o, up_o}, 0);

    // Start and stop together in IDLE: stop wins.
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", busy_o, 0);
    check("startstop_init", init_o, 0);
    run_sweep(0, 12, 3, 0, 1'b0);

    // Midpoint saturation over 301 checks.
    run_sweep(0, 50, 1, 3, 1'b1);

    // Asynchronous reset while a downward step is being issued.
    issue_start(10, 60, 5, 2, 1'b1);
    c = 0;
    while (!(en_o && !up_o) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("rst_reach", c < 2000, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async", {init_o, up_o, en_o, n_o, busy_o, done_o, err_o, pass_o, hits_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(10, 60, 5, 2, 1'b1);

    // Randomized sweeps.
    for (int k = 0; k < 6; k++) begin
      int lo, hi, st, ps;
      lo = $urandom_range(0, 100);
      hi = lo + $urandom_range(1, 120);
      st = $urandom_range(1, 15);
      ps = $urandom_range(0, 4);
      run_sweep(lo, hi, st, ps, 1'($urandom_range(0, 1)));
    end

    check("en_consecutive", consec, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
